// File: rtl/rl_mem_cell_alloc_mp.sv
// Free-list cell allocator: one alloc port, NUM_FREE_PORTS round-robin release ports.
// Optional double-free detection when RL_MEM_ALLOC_DBLFREE_CHK_EN is defined.
module rl_mem_cell_alloc_mp #(
  parameter int unsigned CELL_NUM       = 64,
  parameter int unsigned CELL_ID_WIDTH  = $clog2(CELL_NUM),
  parameter int unsigned CNT_WIDTH      = $clog2(CELL_NUM + 1),
  parameter int unsigned NUM_FREE_PORTS = 2,
  parameter int unsigned INTENSE_THRESH = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    alloc_req_valid_i,
  output logic                                    alloc_req_ready_o,
  output logic                                    alloc_resp_valid_o,
  output logic                                    alloc_resp_ok_o,
  output logic [CELL_ID_WIDTH-1:0]                alloc_resp_cell_id_o,
  input  logic [NUM_FREE_PORTS-1:0]               free_valid_i,
  output logic [NUM_FREE_PORTS-1:0]               free_ready_o,
  input  logic [NUM_FREE_PORTS*CELL_ID_WIDTH-1:0] free_cell_id_i,
  output logic [CNT_WIDTH-1:0]                    free_count_o,
  output logic                                    alloc_intense_o,
  output logic                                    init_done_o,
  output logic                                    dbl_free_err_o
);

  localparam int unsigned PORT_W = (NUM_FREE_PORTS > 1) ? $clog2(NUM_FREE_PORTS) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                   state_q, state_d;
  logic [CELL_ID_WIDTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, init_idx_q, init_idx_d;
  logic [CNT_WIDTH-1:0]     count_q, count_d;
  logic [PORT_W-1:0]        prio_q, prio_d;
  logic                     ready_q, ready_d, resp_valid_q, resp_valid_d;
  logic                     resp_ok_q, resp_ok_d, init_done_q, init_done_d, dbl_q, dbl_d;
  logic [CELL_ID_WIDTH-1:0] resp_id_q, resp_id_d;
  logic [CELL_ID_WIDTH-1:0] ram_q [CELL_NUM];
  logic                     ram_we;
  logic [CELL_ID_WIDTH-1:0] ram_wdata;
  logic                     grant_vld, push, pop;
  logic [PORT_W-1:0]        grant_idx;
  logic [CELL_ID_WIDTH-1:0] grant_cell;
  int unsigned              arb_idx;

  function automatic logic [CELL_ID_WIDTH-1:0] ptr_inc(input logic [CELL_ID_WIDTH-1:0] p);
    return (p == CELL_ID_WIDTH'(CELL_NUM - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin grant starting at prio_q; no grant during INIT or when the list is full.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    for (int unsigned i = 0; i < NUM_FREE_PORTS; i++) begin
      arb_idx = (int'(prio_q) + i) % NUM_FREE_PORTS;
      if (!grant_vld && free_valid_i[PORT_W'(arb_idx)]) begin
        grant_vld = 1'b1;
        grant_idx = PORT_W'(arb_idx);
      end
    end
    if (state_q != ST_RUN || count_q == CNT_WIDTH'(CELL_NUM)) grant_vld = 1'b0;
    free_ready_o = '0;
    if (grant_vld) free_ready_o[grant_idx] = 1'b1;
    grant_cell = free_cell_id_i[grant_idx*CELL_ID_WIDTH +: CELL_ID_WIDTH];
  end

`ifdef RL_MEM_ALLOC_DBLFREE_CHK_EN
  logic [CELL_NUM-1:0] alloc_map_q, alloc_map_d;

  // A free is enqueued only if the cell is currently marked allocated.
  always_comb begin
    push        = grant_vld && alloc_map_q[grant_cell];
    dbl_d       = grant_vld && !alloc_map_q[grant_cell];
    alloc_map_d = alloc_map_q;
    if (state_q == ST_INIT) begin
      alloc_map_d = '0;
    end else begin
      if (pop) alloc_map_d[ram_q[rd_ptr_q]] = 1'b1;
      if (push) alloc_map_d[grant_cell] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) alloc_map_q <= '0;
    else     alloc_map_q <= alloc_map_d;
  end
`else
  always_comb begin
    push  = grant_vld;
    dbl_d = 1'b0;
  end
`endif

  // Next-state: INIT fills the list with 0..CELL_NUM-1, RUN serves alloc and free.
  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    init_idx_d   = init_idx_q;
    count_d      = count_q;
    prio_d       = prio_q;
    ready_d      = ready_q;
    resp_valid_d = 1'b0;
    resp_ok_d    = resp_ok_q;
    resp_id_d    = resp_id_q;
    init_done_d  = init_done_q;
    ram_we       = 1'b0;
    ram_wdata    = grant_cell;
    pop          = 1'b0;
    case (state_q)
      ST_INIT: begin
        ram_we     = 1'b1;
        ram_wdata  = init_idx_q;
        wr_ptr_d   = ptr_inc(wr_ptr_q);
        count_d    = count_q + 1'b1;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == CELL_ID_WIDTH'(CELL_NUM - 1)) begin
          state_d     = ST_RUN;
          ready_d     = 1'b1;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (alloc_req_valid_i && ready_q) begin
          resp_valid_d = 1'b1;
          resp_ok_d    = (count_q != '0);
          if (count_q != '0) begin
            pop       = 1'b1;
            resp_id_d = ram_q[rd_ptr_q];
            rd_ptr_d  = ptr_inc(rd_ptr_q);
          end
        end
        if (grant_vld)
          prio_d = (grant_idx == PORT_W'(NUM_FREE_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        if (push) begin
          ram_we   = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      init_idx_q   <= '0;
      count_q      <= '0;
      prio_q       <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      resp_id_q    <= '0;
      init_done_q  <= 1'b0;
      dbl_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      init_idx_q   <= init_idx_d;
      count_q      <= count_d;
      prio_q       <= prio_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_ok_q    <= resp_ok_d;
      resp_id_q    <= resp_id_d;
      init_done_q  <= init_done_d;
      dbl_q        <= dbl_d;
    end
  end

  // List storage needs no reset; INIT rewrites every entry.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) ram_q[wr_ptr_q] <= ram_wdata;
  end

  assign alloc_req_ready_o    = ready_q;
  assign alloc_resp_valid_o   = resp_valid_q;
  assign alloc_resp_ok_o      = resp_ok_q;
  assign alloc_resp_cell_id_o = resp_id_q;
  assign free_count_o         = count_q;
  assign alloc_intense_o      = (count_q <= CNT_WIDTH'(INTENSE_THRESH));
  assign init_done_o          = init_done_q;
  assign dbl_free_err_o       = dbl_q;

endmodule

// File: tb/tb_rl_mem_cell_alloc_mp.sv
// Bench for rl_mem_cell_alloc_mp: directed scenarios plus random traffic against a queue model.
module tb_rl_mem_cell_alloc_mp;

  localparam int CELL_NUM = 64;
  localparam int CW       = 6;
  localparam int NW       = 7;
  localparam int NP       = 2;
  localparam int THRESH   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             alloc_v;
  logic             alloc_ready, resp_valid, resp_ok;
  logic [CW-1:0]    resp_id;
  logic [NP-1:0]    free_v, free_ready;
  logic [NP*CW-1:0] free_ids;
  logic [NW-1:0]    free_count;
  logic             intense, init_done, dbl_err;

  rl_mem_cell_alloc_mp dut (
    .clk                  (clk),
    .rst                  (rst),
    .alloc_req_valid_i    (alloc_v),
    .alloc_req_ready_o    (alloc_ready),
    .alloc_resp_valid_o   (resp_valid),
    .alloc_resp_ok_o      (resp_ok),
    .alloc_resp_cell_id_o (resp_id),
    .free_valid_i         (free_v),
    .free_ready_o         (free_ready),
    .free_cell_id_i       (free_ids),
    .free_count_o         (free_count),
    .alloc_intense_o      (intense),
    .init_done_o          (init_done),
    .dbl_free_err_o       (dbl_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: free list as a queue, allocation status per cell
  int            fl[$];
  bit            amap[CELL_NUM];
  int            m_prio, m_init_n, m_grant, m_id;
  bit            m_run, m_ready, m_init_done, m_rv, m_ok, m_dbl;
  logic [NP-1:0] last_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    fl.delete();
    foreach (amap[i]) amap[i] = 1'b0;
    m_prio = 0; m_init_n = 0; m_id = 0;
    m_run = 0; m_ready = 0; m_init_done = 0; m_rv = 0; m_ok = 0; m_dbl = 0;
  endfunction

  // One clock: compare at negedge, advance model, return 1 time unit after the edge
  task automatic cycle();
    logic [NP-1:0] exp_ready;
    @(negedge clk);
    m_grant = -1;
    if (m_run && fl.size() < CELL_NUM)
      for (int i = 0; i < NP; i++)
        if (m_grant < 0 && free_v[(m_prio + i) % NP]) m_grant = (m_prio + i) % NP;
    exp_ready = '0;
    if (m_grant >= 0) exp_ready[m_grant] = 1'b1;
    last_ready = free_ready;
    check("free_ready", 32'(free_ready), 32'(exp_ready));
    check("free_count", 32'(free_count), 32'(fl.size()));
    check("alloc_intense", 32'(intense), 32'(fl.size() <= THRESH));
    check("init_done", 32'(init_done), 32'(m_init_done));
    check("alloc_ready", 32'(alloc_ready), 32'(m_ready));
    check("resp_valid", 32'(resp_valid), 32'(m_rv));
    check("resp_ok", 32'(resp_ok), 32'(m_ok));
    check("resp_id", 32'(resp_id), 32'(m_id));
    check("dbl_free_err", 32'(dbl_err), 32'(m_dbl));
    if (rst) begin
      model_reset();
    end else if (!m_run) begin
      m_rv = 0; m_dbl = 0;
      fl.push_back(m_init_n);
      m_init_n++;
      if (m_init_n == CELL_NUM) begin m_run = 1; m_ready = 1; m_init_done = 1; end
    end else begin
      m_rv = alloc_v && m_ready;
      m_dbl = 0;
      if (m_rv) begin
        m_ok = (fl.size() != 0);
        if (m_ok) begin m_id = fl.pop_front(); amap[m_id] = 1'b1; end
      end
      if (m_grant >= 0) begin
        int c;
        c = int'(free_ids[m_grant*CW +: CW]);
        m_prio = (m_grant + 1) % NP;
`ifdef RL_MEM_ALLOC_DBLFREE_CHK_EN
        if (amap[c]) begin amap[c] = 1'b0; fl.push_back(c); end
        else m_dbl = 1;
`else
        fl.push_back(c);
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_init_and_check(input string tag);
    for (int i = 0; i < CELL_NUM - 1; i++) cycle();
    check({tag, "_init_done_early"}, 32'(init_done), 32'd0);
    cycle();
    check({tag, "_init_done"}, 32'(init_done), 32'd1);
    check({tag, "_init_count"}, 32'(free_count), 32'd64);
  endtask

  initial begin
    logic [NP-1:0] e;
    rst = 1'b1; alloc_v = 1'b0; free_v = '0; free_ids = '0;
    @(posedge clk);
    #1;
    model_reset();
    cycle();
    cycle();

    // 1: init completes after 64 cycles; 64 allocs return IDs 0..63
    rst = 1'b0;
    run_init_and_check("t1");
    alloc_v = 1'b1;
    for (int i = 0; i < CELL_NUM; i++) begin
      cycle();
      check("t1_valid", 32'(resp_valid), 32'd1);
      check("t1_ok", 32'(resp_ok), 32'd1);
      check("t1_id", 32'(resp_id), 32'(i));
    end

    // 2: alloc on an empty list
    cycle();
    check("t2_valid", 32'(resp_valid), 32'd1);
    check("t2_ok", 32'(resp_ok), 32'd0);
    check("t2_count", 32'(free_count), 32'd0);
    check("t2_intense", 32'(intense), 32'd1);
    check("t2_id_held", 32'(resp_id), 32'd63);
    alloc_v = 1'b0;

    // 3: refill to 60 alternating ports, then both ports contend
    for (int i = 0; i < 60; i++) begin
      free_v = '0;
      free_v[i % NP] = 1'b1;
      free_ids[(i % NP)*CW +: CW] = CW'(i);
      cycle();
    end
    free_v = '0;
    cycle();
    check("t3_start", 32'(free_count), 32'd60);
    free_v = 2'b11;
    free_ids = {CW'(61), CW'(60)};
    for (int k = 0; k < 4; k++) begin
      cycle();
      e = 2'b01 << (k % 2);
      check("t3_grant", 32'(last_ready), 32'(e));
      free_ids[(k % 2)*CW +: CW] = CW'(62 + (k % 2));
    end
    check("t3_full", 32'(free_count), 32'd64);
    cycle();
    check("t3_stall", 32'(last_ready), 32'd0);
    check("t3_stall_cnt", 32'(free_count), 32'd64);
    free_v = '0;

    // 4: same-cycle alloc and free at 10 and at 0
    alloc_v = 1'b1;
    for (int i = 0; i < 54; i++) cycle();
    check("t4_at10", 32'(free_count), 32'd10);
    free_v = 2'b01; free_ids[0 +: CW] = CW'(5);
    cycle();
    free_v = '0;
    check("t4_ok", 32'(resp_ok), 32'd1);
    check("t4_cnt10", 32'(free_count), 32'd10);
    for (int i = 0; i < 10; i++) cycle();
    check("t4_at0", 32'(free_count), 32'd0);
    free_v = 2'b01; free_ids[0 +: CW] = CW'(5);
    cycle();
    free_v = '0;
    check("t4_empty_ok", 32'(resp_ok), 32'd0);
    check("t4_empty_valid", 32'(resp_valid), 32'd1);
    check("t4_cnt1", 32'(free_count), 32'd1);
    alloc_v = 1'b0;

    // Random traffic; a port holds its request until granted
    for (int n = 0; n < 400; n++) begin
      alloc_v = ($urandom_range(0, 2) != 0);
      for (int p = 0; p < NP; p++) begin
        if (free_v[p] && m_grant == p) free_v[p] = 1'b0;
        if (!free_v[p] && $urandom_range(0, 1) == 0) begin
          free_v[p] = 1'b1;
          free_ids[p*CW +: CW] = CW'($urandom_range(0, CELL_NUM - 1));
        end
      end
      cycle();
    end

    // 5: reset mid-traffic
    rst = 1'b1;
    cycle();
    free_v = 2'b11;
    #1;
    check("t5_ready", 32'(alloc_ready), 32'd0);
    check("t5_rv", 32'(resp_valid), 32'd0);
    check("t5_ok", 32'(resp_ok), 32'd0);
    check("t5_id", 32'(resp_id), 32'd0);
    check("t5_free_ready", 32'(free_ready), 32'd0);
    check("t5_count", 32'(free_count), 32'd0);
    check("t5_init_done", 32'(init_done), 32'd0);
    check("t5_dbl", 32'(dbl_err), 32'd0);
    check("t5_intense", 32'(intense), 32'd1);
    free_v = '0;
    alloc_v = 1'b0;
    rst = 1'b0;
    run_init_and_check("t5");

    // 6: free cell 7 twice after it was allocated
    alloc_v = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    alloc_v = 1'b0;
    check("t6_id7", 32'(resp_id), 32'd7);
    free_v = 2'b01; free_ids[0 +: CW] = CW'(7);
    cycle();
    check("t6_first", 32'(free_count), 32'd57);
    check("t6_first_dbl", 32'(dbl_err), 32'd0);
    cycle();
    free_v = '0;
`ifdef RL_MEM_ALLOC_DBLFREE_CHK_EN
    check("t6_dbl", 32'(dbl_err), 32'd1);
    check("t6_count", 32'(free_count), 32'd57);
`else
    check("t6_dbl", 32'(dbl_err), 32'd0);
    check("t6_count", 32'(free_count), 32'd58);
`endif
    cycle();
    check("t6_dbl_pulse", 32'(dbl_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
